// File: rtl/adpll_pkg.sv
// Shared encodings and helpers for the ADPLL phase/frequency detector.
package adpll_pkg;

    // One-hot measurement states.
    typedef enum logic [2:0] {
        WAITING   = 3'b001,
        REF_FIRST = 3'b010,
        GEN_FIRST = 3'b100
    } pd_state_t;

    // Report modes: full signed count, or sign only.
    localparam logic MODE_PROP = 1'b0;
    localparam logic MODE_BB   = 1'b1;

    // The largest count magnitude for a given error width.
    // The limit is symmetric, so the most negative code is never produced.
    function automatic logic [31:0] sat_limit(input int err_width);
        return (32'd1 << (err_width - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/edge_detector.sv
// Rising-edge detector: one-cycle pulse when a level goes from low to high.
module edge_detector (
    input  logic fpga_clk_i,
    input  logic reset_i,
    input  logic level_i,
    output logic pulse_o
);

    logic level_q;

    // Remember last cycle's level so that a rise can be spotted.
    always_ff @(posedge fpga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_i;
        end
    end

    assign pulse_o = level_i & ~level_q;

endmodule

// File: rtl/phase_error_detector.sv
// Phase/frequency detector for the ADPLL loop: measures the distance in
// clock cycles between reference and generated rising edges and reports it
// as a signed, saturating error word with slip and saturation flags.
module phase_error_detector
    import adpll_pkg::*;
#(
    parameter int ERR_WIDTH         = 16,
    parameter bit BANG_BANG_DEFAULT = 1'b0
) (
    input  logic                        fpga_clk_i,
    input  logic                        reset_i,
    input  logic                        enable_i,
    input  logic                        mode_i,
    input  logic                        reference_synced_i,
    input  logic                        generated_synced_i,
    output logic signed [ERR_WIDTH-1:0] phase_error_o,
    output logic                        error_valid_o,
    output logic                        slip_o,
    output logic                        saturated_o
);

    localparam int CNT_W = ERR_WIDTH - 1;
    localparam logic [CNT_W-1:0] COUNT_MAX = CNT_W'(sat_limit(ERR_WIDTH));
    localparam logic [CNT_W-1:0] COUNT_ONE = CNT_W'(1);

    logic                        ref_pulse;
    logic                        gen_pulse;
    pd_state_t                   state_q;
    logic [CNT_W-1:0]            count_q;
    logic [CNT_W-1:0]            count_inc;
    logic                        count_at_max;
    logic signed [ERR_WIDTH-1:0] pos_err;
    logic signed [ERR_WIDTH-1:0] neg_err;
    logic signed [ERR_WIDTH-1:0] err_q;
    logic                        report_mode_q;

    // Edge history keeps running regardless of enable, so re-enabling never
    // produces a pulse from a level that was already high.
    edge_detector u_ref_edge (
        .fpga_clk_i (fpga_clk_i),
        .reset_i    (reset_i),
        .level_i    (reference_synced_i),
        .pulse_o    (ref_pulse)
    );

    edge_detector u_gen_edge (
        .fpga_clk_i (fpga_clk_i),
        .reset_i    (reset_i),
        .level_i    (generated_synced_i),
        .pulse_o    (gen_pulse)
    );

    assign count_at_max = (count_q == COUNT_MAX);
    assign count_inc    = count_at_max ? count_q : count_q + COUNT_ONE;
    assign pos_err      = $signed({1'b0, count_q});
    assign neg_err      = -pos_err;

    // Measurement FSM: opens on the first edge, closes on the other input's
    // edge (or on a repeated leading edge, flagged as a slip) and registers
    // the report; a closing edge may also open the next measurement.
    always_ff @(posedge fpga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= WAITING;
            count_q       <= '0;
            err_q         <= '0;
            error_valid_o <= 1'b0;
            slip_o        <= 1'b0;
            saturated_o   <= 1'b0;
            report_mode_q <= BANG_BANG_DEFAULT;
        end else begin
            error_valid_o <= 1'b0;
            if (!enable_i) begin
                state_q <= WAITING;
                count_q <= '0;
            end else begin
                case (state_q)
                    WAITING: begin
                        if (ref_pulse && gen_pulse) begin
                            error_valid_o <= 1'b1;
                            err_q         <= '0;
                            slip_o        <= 1'b0;
                            saturated_o   <= 1'b0;
                            report_mode_q <= mode_i;
                        end else if (ref_pulse) begin
                            state_q <= REF_FIRST;
                            count_q <= COUNT_ONE;
                        end else if (gen_pulse) begin
                            state_q <= GEN_FIRST;
                            count_q <= COUNT_ONE;
                        end
                    end
                    REF_FIRST: begin
                        if (ref_pulse || gen_pulse) begin
                            error_valid_o <= 1'b1;
                            err_q         <= pos_err;
                            slip_o        <= ~gen_pulse;
                            saturated_o   <= count_at_max;
                            report_mode_q <= mode_i;
                            state_q       <= ref_pulse ? REF_FIRST : WAITING;
                            count_q       <= ref_pulse ? COUNT_ONE : '0;
                        end else begin
                            count_q <= count_inc;
                        end
                    end
                    GEN_FIRST: begin
                        if (ref_pulse || gen_pulse) begin
                            error_valid_o <= 1'b1;
                            err_q         <= neg_err;
                            slip_o        <= ~ref_pulse;
                            saturated_o   <= count_at_max;
                            report_mode_q <= mode_i;
                            state_q       <= gen_pulse ? GEN_FIRST : WAITING;
                            count_q       <= gen_pulse ? COUNT_ONE : '0;
                        end else begin
                            count_q <= count_inc;
                        end
                    end
                    default: begin
                        state_q <= WAITING;
                        count_q <= '0;
                    end
                endcase
            end
        end
    end

    // Present the stored error either in full or reduced to its sign,
    // according to the mode captured with the report.
    always_comb begin
        if (report_mode_q == MODE_PROP) begin
            phase_error_o = err_q;
        end else if (err_q == '0) begin
            phase_error_o = '0;
        end else if (err_q[ERR_WIDTH-1]) begin
            phase_error_o = '1;
        end else begin
            phase_error_o = ERR_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_phase_error_detector.sv
// Testbench for phase_error_detector: a 16-bit and a 4-bit instance share
// the same stimulus; both are compared each cycle against an edge-timestamp
// model, plus table-driven and hand-written corner-case sequences.
module tb_phase_error_detector;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b1;
    logic mode = 1'b0;
    logic ref_lvl = 1'b0;
    logic gen_lvl = 1'b0;

    logic signed [15:0] pe16;
    logic               valid16, slip16, sat16;
    logic signed [3:0]  pe4;
    logic               valid4, slip4, sat4;

    int checks = 0;
    int failures = 0;

    // Model state: which input opened the measurement and when.
    int m_open = 0;
    int m_t0 = 0;
    int m_cycle = 0;
    bit m_prev_r = 1'b0;
    bit m_prev_g = 1'b0;
    bit e_valid = 1'b0;
    bit e_slip = 1'b0;
    bit e_sat16 = 1'b0;
    bit e_sat4 = 1'b0;
    int e_err16 = 0;
    int e_err4 = 0;

    typedef struct {
        int gap;
        bit md;
        int err16;
        int err4;
        bit sat16;
        bit sat4;
    } vec_t;

    vec_t tbl[8];

    always #5 clk = ~clk;

    phase_error_detector #(.ERR_WIDTH(16), .BANG_BANG_DEFAULT(1'b0)) dut16 (
        .fpga_clk_i         (clk),
        .reset_i            (rst),
        .enable_i           (enable),
        .mode_i             (mode),
        .reference_synced_i (ref_lvl),
        .generated_synced_i (gen_lvl),
        .phase_error_o      (pe16),
        .error_valid_o      (valid16),
        .slip_o             (slip16),
        .saturated_o        (sat16)
    );

    phase_error_detector #(.ERR_WIDTH(4), .BANG_BANG_DEFAULT(1'b0)) dut4 (
        .fpga_clk_i         (clk),
        .reset_i            (rst),
        .enable_i           (enable),
        .mode_i             (mode),
        .reference_synced_i (ref_lvl),
        .generated_synced_i (gen_lvl),
        .phase_error_o      (pe4),
        .error_valid_o      (valid4),
        .slip_o             (slip4),
        .saturated_o        (sat4)
    );

    task automatic checkVal(input string name, input logic signed [63:0] act,
                            input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // A report of separation sep (positive = reference led), saturated per width.
    task automatic modelReport(input int sep, input bit slip, input bit md);
        int mag;
        int sgn;
        int m16;
        int m4;
        mag = (sep < 0) ? -sep : sep;
        sgn = (sep < 0) ? -1 : ((sep > 0) ? 1 : 0);
        m16 = (mag > 32767) ? 32767 : mag;
        m4 = (mag > 7) ? 7 : mag;
        e_valid = 1'b1;
        e_slip = slip;
        e_sat16 = (mag >= 32767);
        e_sat4 = (mag >= 7);
        e_err16 = md ? sgn : sgn * m16;
        e_err4 = md ? sgn : sgn * m4;
    endtask

    task automatic modelCycle(input bit r, input bit g, input bit en, input bit md);
        bit r_rise;
        bit g_rise;
        r_rise = r && !m_prev_r;
        g_rise = g && !m_prev_g;
        m_prev_r = r;
        m_prev_g = g;
        e_valid = 1'b0;
        if (!en) begin
            m_open = 0;
        end else if (m_open == 0) begin
            if (r_rise && g_rise) modelReport(0, 1'b0, md);
            else if (r_rise) begin m_open = 1; m_t0 = m_cycle; end
            else if (g_rise) begin m_open = 2; m_t0 = m_cycle; end
        end else if (m_open == 1) begin
            if (r_rise || g_rise) begin
                modelReport(m_cycle - m_t0, !g_rise, md);
                if (r_rise) m_t0 = m_cycle;
                else m_open = 0;
            end
        end else begin
            if (r_rise || g_rise) begin
                modelReport(-(m_cycle - m_t0), !r_rise, md);
                if (g_rise) m_t0 = m_cycle;
                else m_open = 0;
            end
        end
        m_cycle++;
    endtask

    task automatic checkOutput();
        checkVal("valid16", valid16, e_valid);
        checkVal("valid4", valid4, e_valid);
        checkVal("err16", $signed(pe16), e_err16);
        checkVal("err4", $signed(pe4), e_err4);
        checkVal("slip16", slip16, e_slip);
        checkVal("slip4", slip4, e_slip);
        checkVal("sat16", sat16, e_sat16);
        checkVal("sat4", sat4, e_sat4);
    endtask

    // Drive one cycle of inputs, advance the model, compare after the edge.
    task automatic applyStimulus(input bit r, input bit g, input bit en, input bit md);
        @(negedge clk);
        ref_lvl = r;
        gen_lvl = g;
        enable = en;
        mode = md;
        modelCycle(r, g, en, md);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    // Quiet lead-in, then leading edge and lagging edge gap cycles apart.
    task automatic measure(input int gap, input bit md);
        applyStimulus(1'b0, 1'b0, 1'b1, md);
        applyStimulus(1'b0, 1'b0, 1'b1, md);
        if (gap == 0) begin
            applyStimulus(1'b1, 1'b1, 1'b1, md);
        end else if (gap > 0) begin
            for (int k = 0; k < gap; k++) applyStimulus(1'b1, 1'b0, 1'b1, md);
            applyStimulus(1'b1, 1'b1, 1'b1, md);
        end else begin
            for (int k = 0; k < -gap; k++) applyStimulus(1'b0, 1'b1, 1'b1, md);
            applyStimulus(1'b1, 1'b1, 1'b1, md);
        end
    endtask

    task automatic checkReport(input string name, input int err16, input int err4,
                               input bit slip, input bit s16, input bit s4);
        checkVal({name, "_valid"}, valid16, 1);
        checkVal({name, "_err16"}, $signed(pe16), err16);
        checkVal({name, "_err4"}, $signed(pe4), err4);
        checkVal({name, "_slip"}, slip16, slip);
        checkVal({name, "_sat16"}, sat16, s16);
        checkVal({name, "_sat4"}, sat4, s4);
    endtask

    task automatic doReset();
        @(negedge clk);
        ref_lvl = 1'b0;
        gen_lvl = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkVal("rst_valid", valid16, 0);
        checkVal("rst_err16", $signed(pe16), 0);
        checkVal("rst_err4", $signed(pe4), 0);
        checkVal("rst_slip", slip16, 0);
        checkVal("rst_sat", sat4, 0);
        m_open = 0;
        m_prev_r = 1'b0;
        m_prev_g = 1'b0;
        e_valid = 1'b0;
        e_slip = 1'b0;
        e_sat16 = 1'b0;
        e_sat4 = 1'b0;
        e_err16 = 0;
        e_err4 = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit r;
        bit g;
        bit en;
        bit md;

        tbl[0] = '{gap:  5, md: 1'b0, err16:  5, err4:  5, sat16: 1'b0, sat4: 1'b0};
        tbl[1] = '{gap: -3, md: 1'b1, err16: -1, err4: -1, sat16: 1'b0, sat4: 1'b0};
        tbl[2] = '{gap: -3, md: 1'b0, err16: -3, err4: -3, sat16: 1'b0, sat4: 1'b0};
        tbl[3] = '{gap:  0, md: 1'b0, err16:  0, err4:  0, sat16: 1'b0, sat4: 1'b0};
        tbl[4] = '{gap: 20, md: 1'b0, err16: 20, err4:  7, sat16: 1'b0, sat4: 1'b1};
        tbl[5] = '{gap: -9, md: 1'b0, err16: -9, err4: -7, sat16: 1'b0, sat4: 1'b1};
        tbl[6] = '{gap:  7, md: 1'b1, err16:  1, err4:  1, sat16: 1'b0, sat4: 1'b1};
        tbl[7] = '{gap: -1, md: 1'b0, err16: -1, err4: -1, sat16: 1'b0, sat4: 1'b0};

        #12;
        checkVal("reset_valid", valid16, 0);
        checkVal("reset_err16", $signed(pe16), 0);
        checkVal("reset_slip", slip16, 0);
        checkVal("reset_sat", sat16, 0);
        checkVal("reset_err4", $signed(pe4), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            measure(tbl[i].gap, tbl[i].md);
            checkReport($sformatf("vec%0d", i), tbl[i].err16, tbl[i].err4, 1'b0,
                        tbl[i].sat16, tbl[i].sat4);
            applyStimulus(1'b0, 1'b0, 1'b1, tbl[i].md);
            checkVal($sformatf("vec%0d_strobe", i), valid16, 0);
        end

        // Gen edge coinciding with a second ref edge, then the next gen edge.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkReport("coinc_first", 4, 4, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkReport("coinc_second", 2, 2, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

        // Two ref edges 7 apart: slip, then the restarted measurement closes.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (6) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkReport("slip", 7, 7, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkReport("after_slip", 3, 3, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

        // Enable dropped mid REF_FIRST: gen edge while disabled is ignored.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkVal("dis_novalid", valid16, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkVal("reen_novalid", valid16, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkVal("reen_novalid2", valid4, 0);
        measure(4, 1'b0);
        checkReport("after_enable", 4, 4, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

        // Reset pulsed mid GEN_FIRST, then an exact measurement.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkVal("post_rst_novalid", valid16, 0);
        measure(-2, 1'b0);
        checkReport("after_reset", -2, -2, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

        // Randomised levels, enable and mode against the model.
        r = 1'b0;
        g = 1'b0;
        md = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (i == 400) begin
                doReset();
                r = 1'b0;
                g = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) r = ~r;
            if ($urandom_range(0, 4) == 0) g = ~g;
            if ($urandom_range(0, 9) == 0) md = ~md;
            en = ($urandom_range(0, 39) != 0);
            applyStimulus(r, g, en, md);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
